// File: rtl/oam_dma_pkg.sv
// Shared constants and debug state encoding for the OAM DMA sequencer.
package oam_dma_pkg;
  localparam int         OAM_NBYTES = 160;
  localparam logic [2:0] VRAM_HI    = 3'b100;
  localparam logic [7:0] ECHO_BASE  = 8'hE0;
  localparam logic [7:0] ECHO_OFS   = 8'h20;

  // pend and run may overlap; RUN takes precedence in this view.
  typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_RUN} dma_state_t;
endpackage

// File: rtl/oam_dma_src_map.sv
// Source-page remap and VRAM/external bus classification (combinational).
// Echo-RAM folding of E0-FF onto C0-DF is enabled by OAM_DMA_ECHO_REMAP_EN.
module oam_dma_src_map
  import oam_dma_pkg::*;
(
  input  logic [7:0] pend_base,
  input  logic [7:0] src_hi,
  input  logic       run,
  output logic [7:0] src_next,
  output logic       vram_to_oam,
  output logic       dma_addr_ext
);

  always_comb begin
    src_next = pend_base;
`ifdef OAM_DMA_ECHO_REMAP_EN
    if (pend_base >= ECHO_BASE) src_next = pend_base - ECHO_OFS;
`endif
  end

  assign vram_to_oam  = run && (src_hi[7:5] == VRAM_HI);
  assign dma_addr_ext = run && !vram_to_oam;

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: FF46 write -> start delay -> NBYTES transfers, one per CPB cycles.
// Optional echo remap of the source page via OAM_DMA_ECHO_REMAP_EN (see oam_dma_src_map).
module oam_dma_ctrl
  import oam_dma_pkg::*;
#(
  parameter int CPB         = 4,
  parameter int START_DELAY = 4,
  parameter int NBYTES      = OAM_NBYTES
) (
  input  logic        cclk,
  input  logic        reset,
  input  logic        ff46_wr,
  input  logic [7:0]  d_in,
  output logic [7:0]  ff46_q,
  output logic        dma_run,
  output logic [15:0] dma_a,
  output logic [7:0]  oa_dma,
  output logic        oam_dma_wr,
  output logic        vram_to_oam,
  output logic        dma_addr_ext,
  output logic        dma_done
);

  localparam int PH_W  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int DLY_W = $clog2(START_DELAY + 1);

  logic [7:0]       base_reg, pend_base_reg, src_hi_reg, idx_reg;
  logic [DLY_W-1:0] dly_reg;
  logic [PH_W-1:0]  ph_reg;
  logic             pend_reg, run_reg, done_reg;
  logic [7:0]       src_next;
  dma_state_t       state;
  logic             start, strobe, last;

  always_comb begin
    state = DMA_IDLE;
    if (run_reg)       state = DMA_RUN;
    else if (pend_reg) state = DMA_START;
  end

  // A write landing on the expiry cycle wins, so the stale base never starts.
  assign start  = pend_reg && (dly_reg == DLY_W'(START_DELAY - 1)) && !ff46_wr;
  assign strobe = (state == DMA_RUN) && (ph_reg == PH_W'(CPB - 1));
  assign last   = strobe && (idx_reg == 8'(NBYTES - 1));

  always_ff @(posedge cclk or posedge reset) begin
    if (reset) begin
      base_reg      <= 8'h00;
      pend_base_reg <= 8'h00;
      src_hi_reg    <= 8'h00;
      idx_reg       <= 8'h00;
      dly_reg       <= '0;
      ph_reg        <= '0;
      pend_reg      <= 1'b0;
      run_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= last;
      if (ff46_wr) begin
        base_reg      <= d_in;
        pend_base_reg <= d_in;
        pend_reg      <= 1'b1;
        dly_reg       <= '0;
      end else if (start) begin
        pend_reg <= 1'b0;
      end else if (pend_reg) begin
        dly_reg <= dly_reg + 1'b1;
      end

      // A restart overrides the running transfer after its final old strobe.
      if (start) begin
        run_reg    <= 1'b1;
        idx_reg    <= 8'h00;
        ph_reg     <= '0;
        src_hi_reg <= src_next;
      end else if (run_reg) begin
        ph_reg <= (ph_reg == PH_W'(CPB - 1)) ? '0 : ph_reg + 1'b1;
        if (strobe) begin
          if (last) run_reg <= 1'b0;
          else      idx_reg <= idx_reg + 8'h01;
        end
      end
    end
  end

  oam_dma_src_map u_src_map (
    .pend_base    (pend_base_reg),
    .src_hi       (src_hi_reg),
    .run          (run_reg),
    .src_next     (src_next),
    .vram_to_oam  (vram_to_oam),
    .dma_addr_ext (dma_addr_ext)
  );

  assign ff46_q     = base_reg;
  assign dma_run    = (state == DMA_RUN);
  assign dma_a      = {src_hi_reg, idx_reg};
  assign oa_dma     = idx_reg;
  assign oam_dma_wr = strobe;
  assign dma_done   = done_reg;

endmodule
